// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the grant-state encoding and the width of the ext wait counter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    G_NONE  = 2'd0,
    G_CORE  = 2'd1,
    G_EXT   = 2'd2,
    G_FORCE = 2'd3
  } gnt_state_t;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating wait counter: counts up on inc and holds at MAX.
// clr and reset return it to zero; sat flags that it has reached MAX.
module arb_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [WAIT_W-1:0] count;

  assign sat = (count == WAIT_W'(MAX));

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the data-memory port between the MEM stage (priority) and an ext requester.
// Define DMEM_ARB_STARVE_EN to enable the starvation guard (forced ext slot + core stall).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int bDU      = 32,
  parameter int bADDR    = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             core_rd,
  input  logic             core_wr,
  input  logic [bADDR-1:0] core_addr,
  input  logic [bDU-1:0]   core_wdata,
  output logic [bDU-1:0]   core_rdata,
  output logic             core_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [bADDR-1:0] ext_addr,
  input  logic [bDU-1:0]   ext_wdata,
  output logic             ext_gnt,
  output logic [bDU-1:0]   ext_rdata,
  output logic             ext_rvalid,
  output logic [bADDR-1:0] mem_addr,
  output logic [bDU-1:0]   mem_wdata,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic [bDU-1:0]   mem_rdata,
  output logic [1:0]       gnt_state
);

`ifdef DMEM_ARB_STARVE_EN
  localparam logic STARVE_EN = 1'b1;
`else
  localparam logic STARVE_EN = 1'b0;
`endif

  // Handshake: ext holds req and its fields stable until the cycle ext_gnt is high;
  // the access is performed in that cycle. A stalled core access is retried next cycle
  // with the pipeline holding its inputs.
  logic       core_act;
  logic       wait_sat;
  logic       wait_inc;
  logic       force_slot;
  gnt_state_t grant;
  gnt_state_t gnt_q;

  assign core_act   = core_rd | core_wr;
  assign force_slot = STARVE_EN & ext_req & wait_sat;
  assign core_rdata = mem_rdata;
  assign gnt_state  = gnt_q;

  // Only a core grant with ext waiting advances the counter; anything else clears it.
  assign wait_inc = (grant == G_CORE) & ext_req;

  arb_wait_counter #(
    .MAX(MAX_WAIT)
  ) u_wait_counter (
    .clock(clock),
    .reset(reset),
    .inc  (wait_inc),
    .clr  (~wait_inc),
    .sat  (wait_sat)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_q <= G_NONE;
    end else begin
      gnt_q <= grant;
    end
  end

  always_comb begin
    grant = G_NONE;
    if (reset) begin
      grant = G_NONE;
    end else if (force_slot) begin
      grant = G_FORCE;
    end else if (core_act) begin
      grant = G_CORE;
    end else if (ext_req) begin
      grant = G_EXT;
    end
  end

  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ext_gnt    = 1'b0;
    core_stall = 1'b0;
    case (grant)
      G_CORE: begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_rd    = core_rd;
        mem_wr    = core_wr;
      end
      G_EXT, G_FORCE: begin
        mem_addr   = ext_addr;
        mem_wdata  = ext_wdata;
        mem_rd     = ~ext_we;
        mem_wr     = ext_we;
        ext_gnt    = 1'b1;
        core_stall = (grant == G_FORCE) & core_act;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ext_rdata  <= '0;
      ext_rvalid <= 1'b0;
    end else if (ext_gnt && !ext_we) begin
      ext_rdata  <= mem_rdata;
      ext_rvalid <= 1'b1;
    end else begin
      ext_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a simple memory stub on the arbitrated port.
// Expectations follow DMEM_ARB_STARVE_EN the same way the design does.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        core_rd, core_wr;
  logic [7:0]  core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        ext_req, ext_we;
  logic [7:0]  ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic [31:0] ext_rdata;
  logic        ext_rvalid;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_rdata;
  logic [1:0]  gnt_state;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Clock / reset
  always #5 clock = ~clock;

  dmem_arbiter #(.bDU(32), .bADDR(8), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .gnt_state(gnt_state)
  );

  // Memory stub: combinational read, synchronous write
  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) if (mem_wr) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    core_rd = 0; core_wr = 0; core_addr = 0; core_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  task automatic drive_core(input logic wr, input logic [7:0] a, input logic [31:0] d);
    core_rd = ~wr; core_wr = wr; core_addr = a; core_wdata = d;
  endtask

  task automatic drive_ext(input logic we, input logic [7:0] a, input logic [31:0] d);
    ext_req = 1; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  initial begin
    bit exp_f, prev_f;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Reset with both sides requesting: nothing reaches memory
    reset = 1;
    drive_idle();
    drive_core(1'b1, 8'h10, 32'hAAAA5555);
    drive_ext(1'b1, 8'h30, 32'h55);
    @(negedge clock);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    check("rst_ext_gnt", {31'b0, ext_gnt}, 32'd0);
    check("rst_stall", {31'b0, core_stall}, 32'd0);
    step();
    reset = 0;
    drive_idle();
    @(negedge clock);
    check("rst_gnt_state", {30'b0, gnt_state}, 32'd0);
    check("rst_rvalid", {31'b0, ext_rvalid}, 32'd0);
    check("rst_rdata", ext_rdata, 32'd0);

    // Core write then read-back
    step();
    drive_core(1'b1, 8'h10, 32'hDEADBEEF);
    @(negedge clock);
    check("core_wr_mem_wr", {31'b0, mem_wr}, 32'd1);
    check("core_wr_addr", {24'b0, mem_addr}, 32'h10);
    check("core_wr_data", mem_wdata, 32'hDEADBEEF);
    check("core_wr_stall", {31'b0, core_stall}, 32'd0);
    step();
    drive_core(1'b0, 8'h10, 32'h0);
    @(negedge clock);
    check("core_rd_data", core_rdata, 32'hDEADBEEF);
    check("core_rd_mem_rd", {31'b0, mem_rd}, 32'd1);
    check("core_gnt_state", {30'b0, gnt_state}, 32'd1);

    // Ext-only read, data one cycle later
    step();
    drive_idle();
    drive_ext(1'b0, 8'h10, 32'h0);
    @(negedge clock);
    check("ext_rd_gnt", {31'b0, ext_gnt}, 32'd1);
    check("ext_rd_addr", {24'b0, mem_addr}, 32'h10);
    check("ext_rd_rvalid_early", {31'b0, ext_rvalid}, 32'd0);
    step();
    drive_idle();
    @(negedge clock);
    check("ext_rd_rvalid", {31'b0, ext_rvalid}, 32'd1);
    check("ext_rd_rdata", ext_rdata, 32'hDEADBEEF);
    check("ext_gnt_state", {30'b0, gnt_state}, 32'd2);
    step();
    @(negedge clock);
    check("ext_rvalid_drop", {31'b0, ext_rvalid}, 32'd0);
    check("ext_rdata_hold", ext_rdata, 32'hDEADBEEF);
    check("idle_gnt_state", {30'b0, gnt_state}, 32'd0);
    check("idle_mem_rd", {31'b0, mem_rd}, 32'd0);

    // Ext write, then core reads it back
    step();
    drive_ext(1'b1, 8'h20, 32'h12345678);
    @(negedge clock);
    check("ext_wr_gnt", {31'b0, ext_gnt}, 32'd1);
    check("ext_wr_mem_wr", {31'b0, mem_wr}, 32'd1);
    check("ext_wr_data", mem_wdata, 32'h12345678);
    step();
    drive_idle();
    drive_core(1'b0, 8'h20, 32'h0);
    @(negedge clock);
    check("ext_wr_no_rvalid", {31'b0, ext_rvalid}, 32'd0);
    check("core_rd_ext_data", core_rdata, 32'h12345678);

    // Core busy every cycle with ext read of 0x20 held
    prev_f = 0;
    for (int k = 1; k <= (STARVE ? 20 : 100); k++) begin
      step();
      drive_core(1'b0, 8'h10, 32'h0);
      drive_ext(1'b0, 8'h20, 32'h0);
      exp_f = STARVE && (k % 5 == 0);
      @(negedge clock);
      check($sformatf("busy_gnt_%0d", k), {31'b0, ext_gnt}, {31'b0, exp_f});
      check($sformatf("busy_stall_%0d", k), {31'b0, core_stall}, {31'b0, exp_f});
      check($sformatf("busy_addr_%0d", k), {24'b0, mem_addr}, exp_f ? 32'h20 : 32'h10);
      check($sformatf("busy_state_%0d", k), {30'b0, gnt_state}, prev_f ? 32'd3 : 32'd1);
      if (prev_f) check($sformatf("busy_rdata_%0d", k), ext_rdata, 32'h12345678);
      check($sformatf("busy_rvalid_%0d", k), {31'b0, ext_rvalid}, {31'b0, prev_f});
      prev_f = exp_f;
    end

    // Build wait_cnt up to 3, then reset in the middle of the wait
    step();
    drive_idle();
    for (int k = 1; k <= 3; k++) begin
      step();
      drive_core(1'b1, 8'h40, 32'h0BAD0BAD);
      drive_ext(1'b0, 8'h20, 32'h0);
      @(negedge clock);
      check($sformatf("pre_rst_gnt_%0d", k), {31'b0, ext_gnt}, 32'd0);
    end
    step();
    reset = 1;
    @(negedge clock);
    check("mid_rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    check("mid_rst_ext_gnt", {31'b0, ext_gnt}, 32'd0);
    check("mid_rst_stall", {31'b0, core_stall}, 32'd0);

    // After reset the wait restarts from zero: force lands on the 5th busy cycle
    for (int k = 1; k <= 5; k++) begin
      step();
      reset = 0;
      exp_f = STARVE && (k == 5);
      @(negedge clock);
      if (k == 1) begin
        check("post_rst_state", {30'b0, gnt_state}, 32'd0);
        check("post_rst_rvalid", {31'b0, ext_rvalid}, 32'd0);
      end
      check($sformatf("post_rst_gnt_%0d", k), {31'b0, ext_gnt}, {31'b0, exp_f});
      check($sformatf("post_rst_stall_%0d", k), {31'b0, core_stall}, {31'b0, exp_f});
    end

    step();
    drive_idle();
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port between the pipeline MEM stage (core) and an external loader/debug requester (ext). The core has priority; an optional starvation guard forces an ext slot after a bounded wait and stalls the pipeline for that cycle. The block sits between the EX/MEM register set and the data memory, and drives the pipeline stall that freezes PC and the register sets.

## Interface
- bDU, 32, data width
- bADDR, 8, byte address width into data memory
- MAX_WAIT, 4, cycles ext may wait behind the core before a forced slot (1..15)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- core_rd / core_wr  in  1 each  MEM-stage MemRead / MemWrite (never both high)
- core_addr  in  bADDR  MEM-stage address (ALU result [bADDR-1:0])
- core_wdata  in  bDU  store data
- core_rdata  out  bDU  load data, combinational from mem_rdata
- core_stall  out  1  freeze pipeline this cycle; core access not performed
- ext_req  in  1  ext request; held with its fields until granted
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  bADDR; ext_wdata  in  bDU
- ext_gnt  out  1  ext access performed this cycle
- ext_rdata  out  bDU  registered read data
- ext_rvalid  out  1  ext_rdata valid (one cycle)
- mem_addr  out  bADDR; mem_wdata  out  bDU; mem_rd / mem_wr  out  1 each
- mem_rdata  in  bDU  memory read data (combinational read, synchronous write)
- gnt_state  out  2  registered last-grant state (debug)

## Operation
- core_act = core_rd | core_wr. force = ext_req & (wait_cnt == MAX_WAIT).
- Priority each cycle: reset > force > core_act > ext_req > idle.
- force: ext granted; core_stall = core_act; wait_cnt <= 0.
- core_act (no force): core drives memory; ext_gnt = 0; wait_cnt <= ext_req ? sat(wait_cnt+1, MAX_WAIT) : 0.
- ext only: ext granted; wait_cnt <= 0.
- idle: mem_rd = mem_wr = 0; wait_cnt <= 0.
- Grant mux: mem_addr, mem_wdata, mem_rd, mem_wr come from the granted side; when idle they are zero.
- ext read: ext_rdata <= mem_rdata and ext_rvalid <= 1 on the grant cycle; otherwise ext_rvalid <= 0 and ext_rdata holds its value.
- gnt_state FSM, updated every cycle: G_NONE (0), G_CORE (1), G_EXT (2), G_FORCE (3) = grant type of the cycle just completed.
- Stalled core access retries next cycle; the pipeline holds its inputs stable.
- Reset: wait_cnt = 0, gnt_state = G_NONE, ext_rdata = 0, ext_rvalid = 0. While reset is high, ext_gnt = core_stall = mem_rd = mem_wr = 0 combinationally. Reset mid-wait discards the pending ext request, which the requester must re-present.

## Timing
- Grant, core_stall, mem_* and core_rdata are combinational, with zero latency.
- ext_rvalid and ext_rdata arrive 1 cycle after ext_gnt for a read.
- ext worst-case wait while the core is continuously active: MAX_WAIT+1 cycles, then granted.
- At most one core stall per MAX_WAIT+1 cycles.
- Forced slots are never back-to-back, because wait_cnt clears on every ext grant.

## Configuration
- DMEM_ARB_STARVE_EN defined: starvation guard as above.
- Not defined: force is tied 0, so the core has strict priority and core_stall is constant 0. wait_cnt still counts and saturates but has no effect; ext may starve indefinitely.

## Structure
- Package dmem_arb_pkg holds:
  - gnt_state encoding G_NONE/G_CORE/G_EXT/G_FORCE.
  - Width constant for wait_cnt: 4 bits.
- Sub-module arb_wait_counter: saturating counter with inc/clr inputs, a sat output, and a MAX parameter.

## Test plan
- Core-only traffic: core_wr addr 0x10 data 0xDEADBEEF, then core_rd 0x10 → core_rdata = 0xDEADBEEF same cycle; core_stall never asserts.
- Ext-only read with core idle: ext_req rd addr 0x10 → ext_gnt same cycle; ext_rvalid = 1 with ext_rdata = 0xDEADBEEF the next cycle.
- Core active every cycle, ext_req held, MAX_WAIT = 4 → ext_gnt and core_stall assert on the 5th cycle. The core access repeats the next cycle, and the pattern recurs every 5 cycles.
- Same stimulus with DMEM_ARB_STARVE_EN undefined → ext_gnt and core_stall stay 0 for 100 cycles.
- Simultaneous core_rd and ext_req with wait_cnt = 0 → core granted, ext waits; mem_addr = core_addr.
- Reset asserted while wait_cnt = 3 → same cycle mem_wr = 0 and ext_gnt = 0; next cycle wait_cnt = 0, gnt_state = G_NONE, ext_rvalid = 0.
